// File: rtl/vip_pkg.sv
// Shared types and defaults for the VIP frame-capture slice.
// Holds FSM states, geometry defaults and the stage-1 stream bundle.
package vip_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        ACTIVE
    } cap_state_t;

    localparam int IMG_HDISP       = 640;
    localparam int IMG_VDISP       = 480;
    localparam int HDR_BYTES       = 54;
    localparam int BYTES_PER_PIXEL = 3;

    typedef struct packed {
        logic        clken;
        logic [23:0] data;
        logic        vs_rise;
        logic        vs_fall;
        logic        hr_fall;
    } vip_s1_t;

    function automatic int line_stride(input int hdisp);
        return BYTES_PER_PIXEL * hdisp;
    endfunction

endpackage

// File: rtl/vip_frame_capture_if.sv
// CMOS pixel stream in, frame-buffer write bus out.
// master = stream source / buffer side, slave = capture block.
interface vip_frame_capture_if #(
    parameter int ADDR_W = 20
);
    logic              cmos_vsync;
    logic              cmos_href;
    logic              cmos_clken;
    logic [23:0]       cmos_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;

    modport master (
        output cmos_vsync, cmos_href, cmos_clken, cmos_data,
        input  wr_en, wr_addr, wr_data
    );

    modport slave (
        input  cmos_vsync, cmos_href, cmos_clken, cmos_data,
        output wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/vip_sync_edge.sv
// Stage-1 register of the CMOS stream plus vsync/href edge pulses.
// Edges compare stage 1 against a second delayed copy.
module vip_sync_edge
    import vip_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_vsync,
    input  logic        i_href,
    input  logic        i_clken,
    input  logic [23:0] i_data,
    output vip_s1_t     o_s1
);

    logic        r_vs;
    logic        r_hr;
    logic        r_ck;
    logic [23:0] r_dat;
    logic        r_vs_d;
    logic        r_hr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs   <= 1'b0;
            r_hr   <= 1'b0;
            r_ck   <= 1'b0;
            r_dat  <= '0;
            r_vs_d <= 1'b0;
            r_hr_d <= 1'b0;
        end else begin
            r_vs   <= i_vsync;
            r_hr   <= i_href;
            r_ck   <= i_clken;
            r_dat  <= i_data;
            r_vs_d <= r_vs;
            r_hr_d <= r_hr;
        end
    end

    assign o_s1.clken   = r_ck;
    assign o_s1.data    = r_dat;
    assign o_s1.vs_rise = r_vs & ~r_vs_d;
    assign o_s1.vs_fall = ~r_vs & r_vs_d;
    assign o_s1.hr_fall = ~r_hr & r_hr_d;

endmodule

// File: rtl/vip_frame_capture.sv
// Frame capture into a BMP-layout buffer, 3 bytes per pixel.
// Define VIP_CAP_VFLIP_EN for bottom-up (BMP native) row order.
module vip_frame_capture #(
    parameter int IMG_HDISP = vip_pkg::IMG_HDISP,
    parameter int IMG_VDISP = vip_pkg::IMG_VDISP,
    parameter int HDR_BYTES = vip_pkg::HDR_BYTES,
    parameter int ADDR_W    = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                capture_en,
    vip_frame_capture_if.slave  bus,
    output logic                busy,
    output logic                frame_done,
    output logic                frame_err,
    output logic [15:0]         frame_cnt
);
    import vip_pkg::*;

    localparam int XW = $clog2(IMG_HDISP + 1);
    localparam int YW = $clog2(IMG_VDISP + 2);
    localparam int STRIDE = line_stride(IMG_HDISP);
    localparam logic [ADDR_W-1:0] A_STRIDE = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] A_BPP = ADDR_W'(BYTES_PER_PIXEL);
`ifdef VIP_CAP_VFLIP_EN
    localparam logic [ADDR_W-1:0] BASE0 =
        ADDR_W'(HDR_BYTES + STRIDE * (IMG_VDISP - 1));
`else
    localparam logic [ADDR_W-1:0] BASE0 = ADDR_W'(HDR_BYTES);
`endif

    vip_s1_t w_s1;

    vip_sync_edge u_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_vsync (bus.cmos_vsync),
        .i_href  (bus.cmos_href),
        .i_clken (bus.cmos_clken),
        .i_data  (bus.cmos_data),
        .o_s1    (w_s1)
    );

    cap_state_t        r_state, w_state;
    logic [XW-1:0]     r_x, w_x;
    logic [YW-1:0]     r_y, w_y;
    logic [ADDR_W-1:0] r_base, w_base;
    logic [ADDR_W-1:0] r_off, w_off;
    logic              r_err, w_err;
    logic              r_wr_en, w_wr_en;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr;
    logic [23:0]       r_wr_data, w_wr_data;
    logic              r_done, w_done;
    logic              r_ferr, w_ferr;
    logic [15:0]       r_cnt, w_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_base    <= '0;
            r_off     <= '0;
            r_err     <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state;
            r_x       <= w_x;
            r_y       <= w_y;
            r_base    <= w_base;
            r_off     <= w_off;
            r_err     <= w_err;
            r_wr_en   <= w_wr_en;
            r_wr_addr <= w_wr_addr;
            r_wr_data <= w_wr_data;
            r_done    <= w_done;
            r_ferr    <= w_ferr;
            r_cnt     <= w_cnt;
        end
    end

    // Pixel, then line end, then frame end: later steps see earlier updates.
    always_comb begin
        w_state   = r_state;
        w_x       = r_x;
        w_y       = r_y;
        w_base    = r_base;
        w_off     = r_off;
        w_err     = r_err;
        w_wr_en   = 1'b0;
        w_wr_addr = r_wr_addr;
        w_wr_data = r_wr_data;
        w_done    = 1'b0;
        w_ferr    = 1'b0;
        w_cnt     = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_s1.vs_fall) w_state = SYNC;
            end
            SYNC: begin
                if (w_s1.vs_rise && capture_en) begin
                    w_state = ACTIVE;
                    w_x     = '0;
                    w_y     = '0;
                    w_err   = 1'b0;
                    w_base  = BASE0;
                    w_off   = '0;
                end
            end
            ACTIVE: begin
                if (w_s1.clken) begin
                    if (r_x < XW'(IMG_HDISP) &&
                        r_y < YW'(IMG_VDISP)) begin
                        w_wr_en   = 1'b1;
                        w_wr_addr = r_base + r_off;
                        w_wr_data = w_s1.data;
                        w_x       = r_x + XW'(1);
                        w_off     = r_off + A_BPP;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                if (w_s1.hr_fall) begin
                    if (w_x != XW'(IMG_HDISP)) w_err = 1'b1;
                    if (r_y <= YW'(IMG_VDISP)) w_y = r_y + YW'(1);
                    // Base is dead past the last line; freezing it avoids wrap.
                    if (r_y < YW'(IMG_VDISP - 1)) begin
`ifdef VIP_CAP_VFLIP_EN
                        w_base = r_base - A_STRIDE;
`else
                        w_base = r_base + A_STRIDE;
`endif
                    end
                    w_x   = '0;
                    w_off = '0;
                end
                if (w_s1.vs_fall) begin
                    if (w_y != YW'(IMG_VDISP)) w_err = 1'b1;
                    w_done  = 1'b1;
                    w_ferr  = w_err;
                    w_cnt   = r_cnt + 16'd1;
                    w_state = SYNC;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign bus.wr_en   = r_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;
    assign busy        = (r_state == ACTIVE);
    assign frame_done  = r_done;
    assign frame_err   = r_ferr;
    assign frame_cnt   = r_cnt;

endmodule

// File: tb/tb_vip_frame_capture.sv
// Directed bench for vip_frame_capture, 4x3 frames, 54-byte header.
// Scoreboard model derives addresses from line/pixel indices directly.
module tb_vip_frame_capture;

    localparam int HD = 4;
    localparam int VD = 3;
    localparam int HB = 54;
    localparam int AW = 20;

`ifdef VIP_CAP_VFLIP_EN
    localparam int LIT_FIRST = 78;
    localparam int LIT_L1    = 66;
    localparam int LIT_LAST  = 63;
    localparam int LIT_L2    = 54;
`else
    localparam int LIT_FIRST = 54;
    localparam int LIT_L1    = 66;
    localparam int LIT_LAST  = 87;
    localparam int LIT_L2    = 78;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        logic [23:0]   data;
        int            cyc;
    } wr_t;

    typedef struct {
        logic        err;
        logic [15:0] cnt;
        int          cyc;
    } done_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        capture_en = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        frame_err;
    logic [15:0] frame_cnt;

    vip_frame_capture_if #(.ADDR_W(AW)) bus ();

    vip_frame_capture #(
        .IMG_HDISP (HD),
        .IMG_VDISP (VD),
        .HDR_BYTES (HB),
        .ADDR_W    (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture_en (capture_en),
        .bus        (bus.slave),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_tests = 0;
    int          n_fail = 0;
    int          fid = 0;
    logic [15:0] model_cnt = 16'd0;
    wr_t         exp_q[$];
    done_t       done_q[$];
    wr_t         obs_q[$];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] addr_of(input int l, input int p);
`ifdef VIP_CAP_VFLIP_EN
        return AW'(HB + 3 * HD * (VD - 1 - l) + 3 * p);
`else
        return AW'(HB + 3 * HD * l + 3 * p);
`endif
    endfunction

    function automatic logic [23:0] px(input int f, input int l,
                                       input int p);
        if (l == 0 && p == 0) return 24'h112233;
        if (l == 2 && p == 3) return 24'hAABBCC;
        return {f[7:0], 8'(l * 16 + p), 8'hC3};
    endfunction

    initial begin : compare
        wr_t   e;
        done_t d;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.wr_en) begin
                    obs_q.push_back('{bus.wr_addr, bus.wr_data, cyc});
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL wr_unexpected: addr 0x%0h data 0x%0h, expected no write",
                                 bus.wr_addr, bus.wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                        chk("wr_data", 32'(bus.wr_data), 32'(e.data));
                        chk("wr_cycle", cyc, e.cyc);
                    end
                end
                if (frame_done) begin
                    if (done_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL done_unexpected: frame_done=1, expected 0");
                    end else begin
                        d = done_q.pop_front();
                        chk("frame_err", 32'(frame_err), 32'(d.err));
                        chk("done_cnt", 32'(frame_cnt), 32'(d.cnt));
                        chk("done_cycle", cyc, d.cyc);
                        chk("busy_at_done", 32'(busy), 0);
                    end
                end
            end
        end
    end

    task automatic drive_line(input int l, input int len, input bit cap);
        for (int p = 0; p < len; p++) begin
            bus.cmos_href  = 1'b1;
            bus.cmos_clken = 1'b1;
            bus.cmos_data  = px(fid, l, p);
            if (cap && l < VD && p < HD)
                exp_q.push_back('{addr_of(l, p), px(fid, l, p), cyc + 2});
            tick();
        end
        bus.cmos_clken = 1'b0;
    endtask

    task automatic drive_frame(input int n, input int l0, input int l1,
                               input int l2, input bit arm,
                               input bit cap, input bit tight);
        int lens[3];
        bit err;
        lens = '{l0, l1, l2};
        err  = (n != VD);
        fid++;
        capture_en     = arm;
        bus.cmos_vsync = 1'b1;
        tick();
        tick();
        chk("busy_in_frame", 32'(busy), 32'(cap));
        for (int l = 0; l < n; l++) begin
            drive_line(l, lens[l], cap);
            if (lens[l] != HD) err = 1'b1;
            bus.cmos_href = 1'b0;
            if (tight && l == n - 1) begin
                bus.cmos_vsync = 1'b0;
                if (cap) begin
                    model_cnt++;
                    done_q.push_back('{err, model_cnt, cyc + 2});
                end
                tick();
            end else begin
                tick();
                tick();
            end
        end
        if (!tight) begin
            bus.cmos_vsync = 1'b0;
            if (cap) begin
                model_cnt++;
                done_q.push_back('{err, model_cnt, cyc + 2});
            end
            tick();
        end
        repeat (4) tick();
        chk("wr_missing", exp_q.size(), 0);
        chk("done_missing", done_q.size(), 0);
        chk("frame_cnt", 32'(frame_cnt), 32'(model_cnt));
    endtask

    initial begin : stim
        int mark;
        bus.cmos_vsync = 1'b0;
        bus.cmos_href  = 1'b0;
        bus.cmos_clken = 1'b0;
        bus.cmos_data  = '0;
        repeat (3) tick();
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 0);
        chk("rst_wr_data", 32'(bus.wr_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_err", 32'(frame_err), 0);
        chk("rst_cnt", 32'(frame_cnt), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        mark = obs_q.size();
        drive_frame(3, 4, 4, 4, 1'b1, 1'b0, 1'b0);
        chk("idle_writes", obs_q.size() - mark, 0);
        chk("idle_cnt", 32'(frame_cnt), 0);

        mark = obs_q.size();
        drive_frame(3, 4, 4, 4, 1'b1, 1'b1, 1'b0);
        chk("clean_writes", obs_q.size() - mark, 12);
        if (obs_q.size() - mark == 12) begin
            chk("first_addr", 32'(obs_q[mark].addr), LIT_FIRST);
            chk("first_data", 32'(obs_q[mark].data), 32'h112233);
            chk("line1_addr", 32'(obs_q[mark + 4].addr), LIT_L1);
            chk("last_addr", 32'(obs_q[mark + 11].addr), LIT_LAST);
            chk("last_data", 32'(obs_q[mark + 11].data), 32'hAABBCC);
        end
        chk("clean_cnt", 32'(frame_cnt), 1);

        mark = obs_q.size();
        drive_frame(3, 4, 3, 4, 1'b1, 1'b1, 1'b0);
        chk("short_writes", obs_q.size() - mark, 11);
        if (obs_q.size() - mark == 11)
            chk("short_line2_addr", 32'(obs_q[mark + 7].addr), LIT_L2);

        mark = obs_q.size();
        drive_frame(3, 5, 4, 4, 1'b1, 1'b1, 1'b0);
        chk("long_writes", obs_q.size() - mark, 12);

        drive_frame(3, 4, 4, 4, 1'b1, 1'b1, 1'b0);
        chk("recover_cnt", 32'(frame_cnt), 4);

        mark = obs_q.size();
        drive_frame(3, 4, 4, 4, 1'b0, 1'b0, 1'b0);
        chk("disarm_writes", obs_q.size() - mark, 0);
        chk("disarm_cnt", 32'(frame_cnt), 4);

        drive_frame(3, 4, 4, 4, 1'b1, 1'b1, 1'b1);
        drive_frame(2, 4, 4, 0, 1'b1, 1'b1, 1'b0);
        chk("lines_cnt", 32'(frame_cnt), 6);

        fid++;
        capture_en     = 1'b1;
        bus.cmos_vsync = 1'b1;
        tick();
        tick();
        drive_line(0, 4, 1'b1);
        bus.cmos_href = 1'b0;
        tick();
        tick();
        drive_line(1, 2, 1'b1);
        bus.cmos_href  = 1'b1;
        bus.cmos_clken = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_wr_en", 32'(bus.wr_en), 0);
        chk("mid_wr_addr", 32'(bus.wr_addr), 0);
        chk("mid_wr_data", 32'(bus.wr_data), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_cnt", 32'(frame_cnt), 0);
        exp_q.delete();
        done_q.delete();
        model_cnt = 16'd0;
        bus.cmos_href  = 1'b0;
        bus.cmos_clken = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        bus.cmos_vsync = 1'b0;
        repeat (4) tick();
        chk("post_rst_done", done_q.size(), 0);

        mark = obs_q.size();
        drive_frame(3, 4, 4, 4, 1'b1, 1'b1, 1'b0);
        chk("post_rst_writes", obs_q.size() - mark, 12);
        chk("post_rst_cnt", 32'(frame_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: stimulus not finished, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vip_frame_capture.md
# vip_frame_capture

Synthesizable receiver for the CMOS-style video stream (vsync / href / clken / 24-bit pixel) used across the VIP pipeline. Locks to frame boundaries, counts pixels and lines, and converts each valid pixel into a write to a BMP-layout frame buffer: byte address after the BMP header, 3 bytes per pixel. Sits at the end of the processing chain, where it rebuilds a processed frame for readback, or directly behind a sensor interface. Reports per-frame completion and geometry errors.

## Interface
- IMG_HDISP, 640: active pixels per line.
- IMG_VDISP, 480: active lines per frame.
- HDR_BYTES, 54: byte offset of pixel data (BMP header size).
- ADDR_W, 20: write byte-address width. Must hold HDR_BYTES + 3·HDISP·VDISP − 1.
- clk  in  1  pixel clock.
- rst_n  in  1  reset, asynchronous, active-low.
- capture_en  in  1  arm capture. Sampled only at frame start.
- cmos_vsync  in  1  frame sync. Low = sync interval; high = frame valid.
- cmos_href  in  1  line valid.
- cmos_clken  in  1  pixel valid.
- cmos_data  in  24  pixel, {B,G,R} in bits [23:16],[15:8],[7:0].
- wr_en  out  1  frame-buffer write strobe.
- wr_addr  out  ADDR_W  byte address of wr_data[23:16]. [15:8] goes to +1, [7:0] goes to +2.
- wr_data  out  24  pixel to store.
- busy  out  1  state == ACTIVE.
- frame_done  out  1  one-cycle pulse at end of a captured frame.
- frame_err  out  1  qualified by frame_done: geometry error in that frame.
- frame_cnt  out  16  completed captured frames. Wraps at 0xFFFF→0.

## Operation
- All four stream inputs are registered once (stage S1). Edges are detected between S1 and a second delayed copy.
- FSM states: IDLE, SYNC, ACTIVE.
  - IDLE (after reset): ignore the stream. On a vsync falling edge, go to SYNC. Any partial frame in flight at reset is discarded.
  - SYNC: on a vsync rising edge:
    - if capture_en = 1: clear x, y and the error flag, load the line base, go to ACTIVE;
    - else: stay in SYNC. No writes, no frame_done.
  - ACTIVE, clken high:
    - if x < HDISP and y < VDISP: issue a write, then x += 1 and pixel offset += 3;
    - else: drop the pixel and set the error flag.
  - ACTIVE, href falling edge:
    - if x ≠ HDISP: set the error flag;
    - then y += 1, x = 0, line base += 3·HDISP.
  - ACTIVE, vsync falling edge:
    - if y ≠ VDISP: set the error flag;
    - pulse frame_done with frame_err = error flag, increment frame_cnt, go to SYNC.
  - A vsync falling edge and an href falling edge in the same cycle: process the line end first, then the frame end.
- Address generation: wr_addr = line_base + pixel_offset, built from running accumulators. No multiplier. Normal line_base starts at HDR_BYTES.
- Lines shorter than HDISP still advance line_base by a full 3·HDISP, so following lines stay aligned.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, frame_err=0, frame_cnt=0, state IDLE.
- Latency: clken high at the input in cycle n gives wr_en high in cycle n+2 (S1 register, then registered write outputs). wr_addr and wr_data are valid only while wr_en=1.
- Throughput: one pixel per clock. Back-to-back clken gives back-to-back writes.
- frame_done asserts 2 cycles after the vsync falling edge at the input, for exactly 1 cycle. frame_err is valid in the same cycle.
- The last pixel's write always precedes or coincides with frame_done.
- busy rises 2 cycles after the vsync rising edge (when armed). It falls in the frame_done cycle.
- Reset mid-frame: outputs return to reset values immediately. No frame_done is issued for the aborted frame.

## Configuration
- VIP_CAP_VFLIP_EN defined: BMP bottom-up row order.
  - line_base starts at HDR_BYTES + 3·HDISP·(VDISP−1).
  - line_base decrements by 3·HDISP per line.
  - Lines beyond VDISP are dropped, so underflow cannot occur.
- VIP_CAP_VFLIP_EN undefined: top-down order, line_base increments.
- Error and frame logic are identical in both builds.

## Structure
- Shared package vip_pkg holds:
  - the FSM state enum (IDLE/SYNC/ACTIVE);
  - default IMG_HDISP/IMG_VDISP/HDR_BYTES;
  - the BYTES_PER_PIXEL = 3 constant;
  - the line-stride function 3·HDISP.
- One sub-module: vip_sync_edge. Registers vsync/href/clken/data and outputs delayed copies plus rise/fall pulses for vsync and href.
- FSM, counters and address accumulators live in the top module.

## Test plan
Bench parameters: HDISP=4, VDISP=3, HDR_BYTES=54, capture_en=1 unless stated.
- Reset, then a vsync rising edge with no prior falling edge → no writes, state stays IDLE, all outputs 0.
- Clean 4×3 frame; first pixel 0x112233, last 0xAABBCC (normal build) → 12 writes.
  - First write: wr_addr=54, wr_data=0x112233.
  - Line 1 starts at 66. Last write: wr_addr=87, wr_data=0xAABBCC.
  - frame_done=1, frame_err=0, frame_cnt=1.
- Line 1 carries only 3 pixels → line 2 still starts at 78, 11 writes total, frame_err=1.
- Line 0 carries 5 pixels → 5th pixel not written, frame_err=1. Next frame clean → frame_err=0.
- capture_en=0 at the vsync rising edge → zero writes, no frame_done, frame_cnt unchanged.
- VIP_CAP_VFLIP_EN build with the clean frame → first write at 78, line 1 base 66, last write at 63.
- rst_n pulsed low in mid-line 1 → outputs 0 at once. The next full frame after a vsync falling edge captures cleanly, with frame_cnt=1.
